rs232_receiver: RTL and testbench
=================================

// Module: rs232_receiver
// PURPOSE
//  Receives asynchronous RS232 frames: 1 start bit, 8 data bits sent LSB first,
//  no parity, 1 stop bit. Each received byte is presented with a one-cycle strobe.
//  Counterpart of the transmit path, which is paced by rs232_timer.
//  Has its own bit-period counter, because it must sample at mid-bit rather than on bit edges.
//  Target: 50 MHz main clock (20 ns period).
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); legal range >= 4
//  CNT_WIDTH     16   width of the bit-period counter; must hold CLKS_PER_BIT-1
// PORTS
//  clk           in   1  main clock, rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  rxd           in   1  serial line, idle high; asynchronous to clk
//  data_out      out  8  last good byte; held until the next good byte
//  data_valid    out  1  one-cycle pulse; data_out is new in this cycle
//  frame_error   out  1  one-cycle pulse: stop bit sampled low
//  busy          out  1  high in every state except IDLE
//  state         out  3  current FSM state, for debug
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - outputs: data_out=8'h00, data_valid=0, frame_error=0, busy=0, state=IDLE
//   - internal: synchroniser flops=1, counter=0, bit index=0
//   - entry mid-frame aborts the frame; the partial byte is discarded
//  Synchroniser: rxd passes through 2 flops to give rxd_s; no other logic uses raw rxd.
//  HALF = CLKS_PER_BIT/2 (integer division).
//  FSM encoding: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4; codes 5-7 recover to IDLE.
//  IDLE:
//   - rxd_s==0 -> START, counter=0
//  START:
//   - counter increments each cycle
//   - at counter==HALF-1, sample rxd_s:
//     - 0 -> DATA, counter=0, bit index=0
//     - 1 -> glitch: return to IDLE, no output pulse
//  DATA:
//   - at counter==CLKS_PER_BIT-1, sample rxd_s into the shift register
//     (shift right, new bit enters bit 7), counter=0, bit index+1
//   - after the 8th sample -> STOP
//  STOP:
//   - at counter==CLKS_PER_BIT-1, sample rxd_s:
//     - 1 -> data_out<=shift register, data_valid=1 for 1 cycle, -> IDLE
//     - 0 -> frame_error=1 for 1 cycle, data_out unchanged, -> WAIT_IDLE
//  WAIT_IDLE:
//   - stays until rxd_s==1, then -> IDLE (a break/held-low line never produces bytes)
//  Timing:
//   - each sample is taken about mid-bit
//   - data_valid rises 2 + HALF + 9*CLKS_PER_BIT cycles (+/-2) after the first clk
//     edge that sees rxd low
//  Back-to-back frames:
//   - IDLE is re-entered about half a bit before the stop bit ends,
//     so a start bit right after the stop bit is caught
//  data_valid and frame_error are never high together; each is high for exactly 1 cycle.
//  busy is a combinational decode of state != IDLE.
// TESTING (CLKS_PER_BIT=434, clk period 20 ns, bit time 8680 ns)
//  1. Frame 0x55, stop=1
//     -> one data_valid pulse, data_out=8'h55, frame_error=0, state returns to 0
//  2. 0xA3 then 0x00 back-to-back (no idle gap)
//     -> two data_valid pulses, 8'hA3 then 8'h00
//  3. rxd low for 100 ns (glitch)
//     -> state goes 1 then 0; no data_valid or frame_error
//  4. 0x0F with stop=0, line held low 3 bit times, then frame 0x81
//     -> frame_error pulse, data_out keeps prior value, state=4 while low,
//        then data_out=8'h81
//  5. reset_n low for 50 ns mid-DATA
//     -> all outputs at reset values immediately (async);
//        after release, frame 0x3C is received correctly
//  6. Frames 0xC6 sent with bit time +2% and -2%
//     -> data_out=8'hC6 both times, no frame_error

Source files
------------

// File: rtl/rs232_receiver.sv
// rs232_receiver: 8N1 asynchronous serial receiver with mid-bit sampling.
// The raw line is double-flopped, and a start bit is confirmed at half a bit.
// Data and stop bits are then sampled one full bit period apart. Each good
// byte is presented with a one-cycle data_valid strobe. A low stop bit gives
// a one-cycle frame_error strobe, and the receiver then waits for the line to
// return high before it looks for the next start bit.
module rs232_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  localparam int HALF = CLKS_PER_BIT / 2;
  // Last count of the half-bit start check and of a full bit period
  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic [7:0]           data_out_q;
  logic                 data_valid_q;
  logic                 frame_error_q;

  // Two-flop synchroniser for the asynchronous serial line (resets to idle-high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s = sync_q[1];

  // Receive FSM: bit timing, shift register and registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= CNT_ZERO;
          if (rxd_s == 1'b0) begin
            state_q <= ST_START;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= CNT_ZERO;
            if (rxd_s == 1'b0) begin
              state_q   <= ST_DATA;
              bit_idx_q <= 3'd0;
            end else begin
              // The line went back high too early: treat it as a glitch
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= CNT_ZERO;
            shift_q   <= {rxd_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            // Leaving here at mid stop bit leaves half a bit to catch the next start
            cnt_q <= CNT_ZERO;
            if (rxd_s == 1'b1) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_IDLE: begin
          cnt_q <= CNT_ZERO;
          if (rxd_s == 1'b1) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_IDLE;
          end
        end
        default: begin
          // Codes 5 to 7 are unused and fall back to IDLE
          state_q   <= ST_IDLE;
          cnt_q     <= CNT_ZERO;
          bit_idx_q <= 3'd0;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign state       = state_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs232_receiver.sv
// Directed bench for rs232_receiver. A scoreboard queue holds the expected bytes.
`timescale 1ns/1ps
module tb_rs232_receiver;

  localparam int CPB     = 434;
  localparam int BIT_NS  = 8680;
  localparam int LATENCY = 2 + CPB/2 + 9*CPB;

  logic       clk;
  logic       reset_n;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic [2:0] state;

  int         total;
  int         bad;
  int         fe_seen;
  logic       dv_prev;
  logic       fe_prev;
  time        dv_t;
  time        t0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         fe_base;
  int         lat;

  rs232_receiver #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .data_out(data_out),
    .data_valid(data_valid), .frame_error(frame_error), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bt, input bit push);
    if (push) sb.push_back(b);
    rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bt);
    end
    rxd = stop_bit;
    #(bt);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((sb.size() != 0 || state !== 3'd0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_idle"}, {29'd0, state}, 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every data_valid and checks the strobe rules
  always @(negedge clk) begin
    if (data_valid || frame_error) begin
      total++;
      assert (!(data_valid && frame_error)) else begin
        bad++;
        $error("FAIL both_strobes observed=11 expected=not_both");
      end
    end
    if (data_valid) begin
      dv_t = $time;
      total++;
      assert (!dv_prev) else begin
        bad++;
        $error("FAIL dv_width observed=multi_cycle expected=1_cycle");
      end
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_dv observed=%0h expected=no_pulse", data_out);
      end
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        total++;
        assert (data_out === exp_b) else begin
          bad++;
          $error("FAIL data_out observed=%0h expected=%0h", data_out, exp_b);
        end
      end
    end
    if (frame_error) begin
      fe_seen++;
      total++;
      assert (!fe_prev) else begin
        bad++;
        $error("FAIL fe_width observed=multi_cycle expected=1_cycle");
      end
    end
    dv_prev = data_valid;
    fe_prev = frame_error;
  end

  initial begin
    total = 0; bad = 0; fe_seen = 0; dv_prev = 1'b0; fe_prev = 1'b0; dv_t = 0;
    reset_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_fe", {31'd0, frame_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: single frame 0x55, latency check against the first edge that sees rxd low
    @(negedge clk);
    t0 = $time;
    send_frame(8'h55, 1'b1, BIT_NS, 1'b1);
    wait_idle("t1", 2000);
    lat = int'((dv_t - t0 - 20) / 20);
    chk("t1_latency_ok", {31'd0, (lat >= LATENCY - 2) && (lat <= LATENCY + 2)}, 32'd1);
    chk("t1_fe", fe_seen, 0);

    // 2: back-to-back 0xA3 then 0x00 with no idle gap
    send_frame(8'hA3, 1'b1, BIT_NS, 1'b1);
    send_frame(8'h00, 1'b1, BIT_NS, 1'b1);
    wait_idle("t2", 2000);

    // 3: 100 ns glitch gives START then IDLE and no strobes
    @(negedge clk);
    rxd = 1'b0;
    #100;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_state_start", {29'd0, state}, 32'd1);
    repeat (300) @(negedge clk);
    chk("t3_state_idle", {29'd0, state}, 32'd0);
    chk("t3_fe", fe_seen, 0);
    chk("t3_data_out", {24'd0, data_out}, 32'h00);

    // 4: bad stop bit, line held low, then a good frame 0x81
    fe_base = fe_seen;
    send_frame(8'h0F, 1'b0, BIT_NS, 1'b0);
    #(BIT_NS);
    chk("t4_state_wait", {29'd0, state}, 32'd4);
    chk("t4_fe_count", fe_seen - fe_base, 1);
    chk("t4_data_kept", {24'd0, data_out}, 32'h00);
    #(2*BIT_NS);
    chk("t4_state_still_wait", {29'd0, state}, 32'd4);
    rxd = 1'b1;
    #(BIT_NS);
    chk("t4_state_idle", {29'd0, state}, 32'd0);
    send_frame(8'h81, 1'b1, BIT_NS, 1'b1);
    wait_idle("t4", 2000);

    // 5: async reset in the middle of DATA, then frame 0x3C
    @(negedge clk);
    rxd = 1'b0;
    #(BIT_NS);
    rxd = 1'b1;
    #(BIT_NS/2);
    chk("t5_state_data", {29'd0, state}, 32'd2);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #5;
    chk("t5_rst_state", {29'd0, state}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_data_out", {24'd0, data_out}, 32'h00);
    chk("t5_rst_dv", {31'd0, data_valid}, 32'd0);
    chk("t5_rst_fe", {31'd0, frame_error}, 32'd0);
    #45;
    reset_n = 1'b1;
    #(BIT_NS);
    send_frame(8'h3C, 1'b1, BIT_NS, 1'b1);
    wait_idle("t5", 2000);

    // 6: 0xC6 with bit time +2% and -2%
    send_frame(8'hC6, 1'b1, 8854, 1'b1);
    wait_idle("t6_slow", 2000);
    send_frame(8'hC6, 1'b1, 8506, 1'b1);
    wait_idle("t6_fast", 2000);
    chk("t6_data_out", {24'd0, data_out}, 32'hC6);
    chk("final_fe_count", fe_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
